// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// D wins by default; a starvation counter forces an I grant after STARVE_MAX back-to-back D grants.
module mem_port_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_stall,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_done,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_stall,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [AWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DWIDTH-1:0] m_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     starve_cnt_reg, starve_cnt_next;
  logic              drop_reg, drop_next;
  logic              m_we_reg, m_we_next;
  logic [AWIDTH-1:0] m_addr_reg, m_addr_next;
  logic [DWIDTH-1:0] m_wdata_reg, m_wdata_next;
  logic [DWIDTH-1:0] if_rdata_reg, if_rdata_next;
  logic [DWIDTH-1:0] d_rdata_reg, d_rdata_next;

  logic force_i;
  logic grant_d;
  logic grant_i;
  logic drop_now;

  // Arbitration happens only in IDLE; a saturated counter with fetch pending blocks D.
  always_comb begin
    force_i  = if_req && (starve_cnt_reg == STARVE_LIMIT);
    grant_d  = (state_reg == IDLE) && d_req && !force_i;
    grant_i  = (state_reg == IDLE) && !grant_d && if_req && !if_flush;
    drop_now = drop_reg || if_flush;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          // A fetch cancelled while in flight completes silently.
          state_next = drop_now ? IDLE : DONE_I;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          state_next = DONE_D;
        end
      end
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_req    = (state_reg == BUSY_I) || (state_reg == BUSY_D);
    if_done  = (state_reg == DONE_I) && !if_flush;
    d_done   = (state_reg == DONE_D);
    if_stall = if_req && !if_done;
    d_stall  = d_req && !d_done;
    m_we     = m_we_reg;
    m_addr   = m_addr_reg;
    m_wdata  = m_wdata_reg;
    if_rdata = if_rdata_reg;
    d_rdata  = d_rdata_reg;
  end

  // Datapath and bookkeeping next values
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    drop_next       = 1'b0;
    m_we_next       = m_we_reg;
    m_addr_next     = m_addr_reg;
    m_wdata_next    = m_wdata_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;

    if (state_reg == IDLE) begin
      if (grant_d && if_req) begin
        if (starve_cnt_reg != STARVE_LIMIT) begin
          starve_cnt_next = starve_cnt_reg + CW'(1);
        end
      end else if (grant_i || !if_req) begin
        starve_cnt_next = '0;
      end
    end

    if (grant_d) begin
      m_we_next    = d_we;
      m_addr_next  = d_addr;
      m_wdata_next = d_wdata;
    end else if (grant_i) begin
      m_we_next    = 1'b0;
      m_addr_next  = if_addr;
      m_wdata_next = '0;
    end

    if (state_reg == BUSY_I) begin
      drop_next = drop_now;
      if (m_ack && !drop_now) begin
        if_rdata_next = m_rdata;
      end
    end

    // Stores also capture m_rdata; the value is meaningless but harmless.
    if ((state_reg == BUSY_D) && m_ack) begin
      d_rdata_next = m_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      drop_reg       <= 1'b0;
      m_we_reg       <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      drop_reg       <= drop_next;
      m_we_reg       <= m_we_next;
      m_addr_reg     <= m_addr_next;
      m_wdata_reg    <= m_wdata_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; a small memory model acks after mem_lat cycles of m_req
// and returns m_addr + 0x1000_0000 as read data.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int tests;
  int fails;
  int mem_lat;
  int lat_cnt;
  bit auto_mem;

  mem_port_arbiter #(
    .DWIDTH    (32),
    .AWIDTH    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_flush(if_flush),
    .if_done (if_done),
    .if_rdata(if_rdata),
    .if_stall(if_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .d_stall (d_stall),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: counts cycles with m_req high and acks on the mem_lat-th one.
  initial begin
    lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (m_req) begin
          lat_cnt = lat_cnt + 1;
          if (lat_cnt == mem_lat) begin
            m_ack   = 1'b1;
            m_rdata = m_addr + 32'h1000_0000;
            lat_cnt = 0;
          end else begin
            m_ack = 1'b0;
          end
        end else begin
          m_ack   = 1'b0;
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    #1;
    tests++;
    if ({m_req, m_we, if_done, d_done} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got req/we/ifd/dd=%b want 0000", {m_req, m_we, if_done, d_done});
    end
    tests++;
    if ((m_addr | m_wdata | if_rdata | d_rdata) !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wdata=%h ifr=%h dr=%h want all 0",
               m_addr, m_wdata, if_rdata, d_rdata);
    end
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_single_fetch();
    cyc();
    mem_lat = 2;
    if_req  = 1'b1;
    if_addr = 32'h10;
    #1;
    tests++;
    if (if_stall !== 1'b1 || m_req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_t0: got stall=%b m_req=%b want 1 0", if_stall, m_req);
    end
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0 || if_stall !== 1'b1) begin
      fails++;
      $display("FAIL fetch_t1: got m_req=%b addr=%h we=%b stall=%b want 1 10 0 1",
               m_req, m_addr, m_we, if_stall);
    end
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || if_done !== 1'b0) begin
      fails++;
      $display("FAIL fetch_t2: got m_req=%b if_done=%b want 1 0", m_req, if_done);
    end
    cyc(); #1;
    tests++;
    if (if_done !== 1'b1 || if_rdata !== 32'h1000_0010 || if_stall !== 1'b0 || m_req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_t3: got done=%b rdata=%h stall=%b m_req=%b want 1 10000010 0 0",
               if_done, if_rdata, if_stall, m_req);
    end
    if_req = 1'b0;
    cyc(); #1;
    tests++;
    if (if_done !== 1'b0) begin
      fails++;
      $display("FAIL fetch_t4: got if_done=%b want 0", if_done);
    end
    $display("[TB] single fetch addr=0x10 rdata=%h", if_rdata);
  endtask

  task automatic test_simultaneous();
    cyc();
    mem_lat = 1;
    if_req  = 1'b1;
    if_addr = 32'h20;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h40) begin
      fails++;
      $display("FAIL simul_dfirst: got m_req=%b addr=%h want 1 40", m_req, m_addr);
    end
    cyc(); #1;
    tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'h1000_0040 || if_done !== 1'b0) begin
      fails++;
      $display("FAIL simul_ddone: got d_done=%b d_rdata=%h if_done=%b want 1 10000040 0",
               d_done, d_rdata, if_done);
    end
    d_req = 1'b0;
    cyc();
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h20) begin
      fails++;
      $display("FAIL simul_ithen: got m_req=%b addr=%h want 1 20", m_req, m_addr);
    end
    cyc(); #1;
    tests++;
    if (if_done !== 1'b1 || if_rdata !== 32'h1000_0020 || d_done !== 1'b0) begin
      fails++;
      $display("FAIL simul_idone: got if_done=%b if_rdata=%h d_done=%b want 1 10000020 0",
               if_done, if_rdata, d_done);
    end
    if_req = 1'b0;
    cyc();
    $display("[TB] simultaneous: D then I served");
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    logic [1:0]  exp_done;
    cyc();
    mem_lat = 1;
    if_req  = 1'b1;
    if_addr = 32'h24;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h44;
    for (int i = 0; i < 15; i++) begin
      exp_addr = (i % 5 == 4) ? 32'h24 : 32'h44;
      exp_done = (i % 5 == 4) ? 2'b10 : 2'b01;
      cyc(); #1;
      tests++;
      if (m_req !== 1'b1 || m_addr !== exp_addr) begin
        fails++;
        $display("FAIL starve_grant%0d: got m_req=%b addr=%h want 1 %h", i, m_req, m_addr, exp_addr);
      end
      cyc(); #1;
      tests++;
      if ({if_done, d_done} !== exp_done) begin
        fails++;
        $display("FAIL starve_done%0d: got if/d done=%b want %b", i, {if_done, d_done}, exp_done);
      end
      $display("[TB] starvation grant %0d addr=%h", i, m_addr);
      if (i == 14) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      cyc();
    end
  endtask

  task automatic test_store();
    cyc();
    mem_lat = 3;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h80;
    d_wdata = 32'hDEAD_BEEF;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h80 || m_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h want 1 1 80 deadbeef",
               m_req, m_we, m_addr, m_wdata);
    end
    d_wdata = 32'h1234_5678;
    cyc(); #1;
    tests++;
    if (m_wdata !== 32'hDEAD_BEEF || m_we !== 1'b1 || d_done !== 1'b0) begin
      fails++;
      $display("FAIL store_hold1: got wdata=%h we=%b d_done=%b want deadbeef 1 0", m_wdata, m_we, d_done);
    end
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || d_done !== 1'b0) begin
      fails++;
      $display("FAIL store_hold2: got req=%b wdata=%h d_done=%b want 1 deadbeef 0", m_req, m_wdata, d_done);
    end
    cyc(); #1;
    tests++;
    if (d_done !== 1'b1 || m_req !== 1'b0 || d_stall !== 1'b0) begin
      fails++;
      $display("FAIL store_done: got d_done=%b m_req=%b d_stall=%b want 1 0 0", d_done, m_req, d_stall);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    cyc(); #1;
    tests++;
    if (d_done !== 1'b0) begin
      fails++;
      $display("FAIL store_pulse: got d_done=%b want 0", d_done);
    end
    $display("[TB] store addr=0x80 wdata=deadbeef");
  endtask

  task automatic test_flush();
    cyc();
    mem_lat  = 3;
    if_req   = 1'b1;
    if_addr  = 32'h30;
    if_flush = 1'b1;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_block: got m_req=%b want 0", m_req);
    end
    if_flush = 1'b0;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h30) begin
      fails++;
      $display("FAIL flush_grant: got m_req=%b addr=%h want 1 30", m_req, m_addr);
    end
    if_flush = 1'b1;
    cyc();
    if_flush = 1'b0;
    if_req   = 1'b0;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1) begin
      fails++;
      $display("FAIL flush_runs: got m_req=%b want 1", m_req);
    end
    cyc(); #1;
    tests++;
    if (if_done !== 1'b0 || m_req !== 1'b0 || if_rdata !== 32'h1000_0024) begin
      fails++;
      $display("FAIL flush_drop: got if_done=%b m_req=%b if_rdata=%h want 0 0 10000024",
               if_done, m_req, if_rdata);
    end
    mem_lat = 1;
    if_req  = 1'b1;
    if_addr = 32'h50;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h50) begin
      fails++;
      $display("FAIL flush_fresh_grant: got m_req=%b addr=%h want 1 50", m_req, m_addr);
    end
    cyc(); #1;
    tests++;
    if (if_done !== 1'b1 || if_rdata !== 32'h1000_0050) begin
      fails++;
      $display("FAIL flush_fresh_done: got if_done=%b if_rdata=%h want 1 10000050", if_done, if_rdata);
    end
    if_req = 1'b0;
    cyc();
    $display("[TB] flush in BUSY_I dropped, refetch addr=0x50 rdata=%h", if_rdata);
  endtask

  task automatic test_reset_mid_access();
    cyc();
    mem_lat = 10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h90;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b1 || m_addr !== 32'h90) begin
      fails++;
      $display("FAIL rstmid_busy: got m_req=%b addr=%h want 1 90", m_req, m_addr);
    end
    rst = 1'b1;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b0 || m_addr !== 32'h0 || d_done !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_clear: got m_req=%b addr=%h d_done=%b d_rdata=%h if_rdata=%h want 0 0 0 0 0",
               m_req, m_addr, d_done, d_rdata, if_rdata);
    end
    rst      = 1'b0;
    d_req    = 1'b0;
    auto_mem = 1'b0;
    m_ack    = 1'b1;
    m_rdata  = 32'hBAD0_BAD0;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b0 || d_done !== 1'b0 || d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_lateack: got m_req=%b d_done=%b d_rdata=%h want 0 0 0", m_req, d_done, d_rdata);
    end
    m_ack = 1'b0;
    cyc(); #1;
    tests++;
    if (m_req !== 1'b0 || d_done !== 1'b0 || if_done !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_quiet: got m_req=%b d_done=%b if_done=%b want 0 0 0", m_req, d_done, if_done);
    end
    auto_mem = 1'b1;
    $display("[TB] reset during BUSY_D abandoned access");
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    mem_lat  = 1;
    auto_mem = 1'b1;
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    if_flush = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    m_ack    = 1'b0;
    m_rdata  = 32'h0;

    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid_access();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
